// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: the per-stage slot entry and the
// register-match rule used by both the stall detector and the forwarders.
package hazard_pkg;

  localparam int NREG_DEF = 32;
  localparam int RW       = $clog2(NREG_DEF);

  localparam int SLOT_EXE = 0;
  localparam int SLOT_ACC = 1;
  localparam int SLOT_WB  = 2;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          wen;
    logic          load;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          use1;
    logic          use2;
  } slot_t;

  // x0 is hardwired to zero, so it can never be a real dependency.
  function automatic logic slot_match(input slot_t s, input logic [RW-1:0] rs);
    return s.valid && s.wen && (s.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Priority search over slots 1..DEPTH-1 for the youngest writer of one EXE
// operand; returns that slot's writeback value.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3
) (
  input  slot_t                       i_slot [DEPTH],
  input  logic                        i_req,
  input  logic [RW-1:0]               i_rs,
  input  logic [(DEPTH-1)*XLEN-1:0]   i_wdata,
  output logic                        o_en,
  output logic [XLEN-1:0]             o_data
);

  logic [DEPTH-1:SLOT_ACC] w_hit;

  genvar gi;
  generate
    for (gi = SLOT_ACC; gi < DEPTH; gi++) begin : g_hit
      assign w_hit[gi] = i_req && slot_match(i_slot[gi], i_rs);
    end
  endgenerate

  // Walk oldest to youngest so the lowest matching index is the last to win.
  always_comb begin
    o_en   = 1'b0;
    o_data = '0;
    for (int i = DEPTH - 1; i >= SLOT_ACC; i--) begin
      if (w_hit[i]) begin
        o_en   = 1'b1;
        o_data = i_wdata[(i-1)*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight writer scoreboard for the RV32 pipeline: load-use stall,
// EXE operand forwarding and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      de_valid,
  input  logic [$clog2(NREG)-1:0]   de_rs1,
  input  logic [$clog2(NREG)-1:0]   de_rs2,
  input  logic                      de_use_rs1,
  input  logic                      de_use_rs2,
  input  logic [$clog2(NREG)-1:0]   de_rd,
  input  logic                      de_wen,
  input  logic                      de_load,
  input  logic                      flush,
  input  logic [DEPTH*XLEN-1:0]     stage_wdata,
  output logic                      stall,
  output logic                      fwd_a_en,
  output logic                      fwd_b_en,
  output logic [XLEN-1:0]           fwd_a_data,
  output logic [XLEN-1:0]           fwd_b_data,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          stall_cnt
);

  slot_t            r_slot [DEPTH];
  slot_t            w_slot0_next;
  logic [DEPTH-1:0] w_load_hit;
  logic             w_hazard;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_unused;

  // Slot 0 is still in EXE and has produced nothing yet.
  assign w_unused = ^stage_wdata[XLEN-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
      if (gi + 1 < LOAD_READY) begin : g_early
        assign w_load_hit[gi] = r_slot[gi].load &&
            ((de_use_rs1 && slot_match(r_slot[gi], de_rs1)) ||
             (de_use_rs2 && slot_match(r_slot[gi], de_rs2)));
      end else begin : g_late
        assign w_load_hit[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_hazard = de_valid && (|w_load_hit);
  assign stall    = w_hazard && !flush;

  always_comb begin
    w_slot0_next = '0;
    if (de_valid && !stall && !flush) begin
      w_slot0_next.valid = 1'b1;
      w_slot0_next.rd    = de_rd;
      w_slot0_next.wen   = de_wen;
      w_slot0_next.load  = de_load;
      w_slot0_next.rs1   = de_rs1;
      w_slot0_next.rs2   = de_rs2;
      w_slot0_next.use1  = de_use_rs1;
      w_slot0_next.use2  = de_use_rs2;
    end
  end

  // Later slots always advance; a stall only injects a bubble into slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
    end else begin
      r_slot[SLOT_EXE] <= w_slot0_next;
      for (int i = 1; i < DEPTH; i++) r_slot[i] <= r_slot[i-1];
    end
  end

  fwd_select #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fwd_a (
    .i_slot  (r_slot),
    .i_req   (r_slot[SLOT_EXE].valid && r_slot[SLOT_EXE].use1),
    .i_rs    (r_slot[SLOT_EXE].rs1),
    .i_wdata (stage_wdata[DEPTH*XLEN-1:XLEN]),
    .o_en    (fwd_a_en),
    .o_data  (fwd_a_data)
  );

  fwd_select #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fwd_b (
    .i_slot  (r_slot),
    .i_req   (r_slot[SLOT_EXE].valid && r_slot[SLOT_EXE].use2),
    .i_rs    (r_slot[SLOT_EXE].rs2),
    .i_wdata (stage_wdata[DEPTH*XLEN-1:XLEN]),
    .o_en    (fwd_b_en),
    .o_data  (fwd_b_data)
  );

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default instance plus a DEPTH=4 / LOAD_READY=3 instance
// with a narrow counter so saturation is reachable in a few cycles.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, de_valid, de_use_rs1, de_use_rs2, de_wen, de_load, flush, cnt_clr;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic [95:0]  stage_wdata;
  logic [127:0] stage_wdata4;

  logic        stall, fwd_a_en, fwd_b_en;
  logic [31:0] fwd_a_data, fwd_b_data;
  logic [15:0] stall_cnt;

  logic        stall4, fwd_a_en4, fwd_b_en4;
  logic [31:0] fwd_a_data4, fwd_b_data4;
  logic [3:0]  stall_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_rd(de_rd), .de_wen(de_wen),
    .de_load(de_load), .flush(flush), .stage_wdata(stage_wdata), .stall(stall),
    .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en), .fwd_a_data(fwd_a_data),
    .fwd_b_data(fwd_b_data), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.DEPTH(4), .LOAD_READY(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_rd(de_rd), .de_wen(de_wen),
    .de_load(de_load), .flush(flush), .stage_wdata(stage_wdata4), .stall(stall4),
    .fwd_a_en(fwd_a_en4), .fwd_b_en(fwd_b_en4), .fwd_a_data(fwd_a_data4),
    .fwd_b_data(fwd_b_data4), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic wen, input logic ld);
    de_valid = v; de_rs1 = rs1; de_use_rs1 = u1; de_rs2 = rs2; de_use_rs2 = u2;
    de_rd = rd; de_wen = wen; de_load = ld;
  endtask

  task automatic idle;
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain;
    idle();
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    stage_wdata = '0; stage_wdata4 = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_fwd_a_en", fwd_a_en, 0);
    chk("reset_fwd_a_data", fwd_a_data, 0);
    chk("reset_fwd_b_en", fwd_b_en, 0);
    chk("reset_fwd_b_data", fwd_b_data, 0);
    chk("reset_cnt", stall_cnt, 0);

    // add x5,x1,x2 ; sub x6,x5,x3
    dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    #1 chk("add_stall", stall, 0);
    tick();
    dec(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 chk("sub_stall", stall, 0);
    chk("add_no_fwd_a", fwd_a_en, 0);
    tick();
    idle();
    stage_wdata[63:32] = 32'h0000_0011;
    #1;
    chk("sub_fwd_a_en", fwd_a_en, 1);
    chk("sub_fwd_a_data", fwd_a_data, 32'h11);
    chk("sub_fwd_b_en", fwd_b_en, 0);
    drain();

    // lw x7 ; add x8,x7,x7
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    #1 chk("lu_stall_c1", stall, 1);
    tick();
    #1 chk("lu_stall_c2", stall, 0);
    tick();
    idle();
    stage_wdata[63:32] = 32'h1234_5678;
    stage_wdata[95:64] = 32'hDEAD_BEEF;
    #1;
    chk("lu_fwd_a_en", fwd_a_en, 1);
    chk("lu_fwd_a_data", fwd_a_data, 32'hDEAD_BEEF);
    chk("lu_fwd_b_en", fwd_b_en, 1);
    chk("lu_fwd_b_data", fwd_b_data, 32'hDEAD_BEEF);
    chk("lu_cnt", stall_cnt, 1);
    drain();

    // two writers of x9, youngest must win
    dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    #1 chk("yw_stall", stall, 0);
    tick();
    idle();
    stage_wdata[63:32] = 32'h1;
    stage_wdata[95:64] = 32'h2;
    #1;
    chk("yw_fwd_a_en", fwd_a_en, 1);
    chk("yw_fwd_a_data", fwd_a_data, 32'h1);
    chk("yw_fwd_b_x0_en", fwd_b_en, 0);
    drain();

    // load writing x0 followed by a reader of x0
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    #1 chk("x0_stall", stall, 0);
    tick();
    idle();
    stage_wdata[63:32] = 32'h0000_AAAA;
    #1;
    chk("x0_fwd_a_en", fwd_a_en, 0);
    chk("x0_fwd_a_data", fwd_a_data, 0);
    drain();

    // load-use hazard with a simultaneous flush
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    idle();
    #1;
    chk("flush_slot0_bubble", fwd_a_en, 0);
    chk("flush_cnt", stall_cnt, 1);
    drain();

    // clear during a stall cycle wins over the increment
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1 chk("clr_stall", stall, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    idle();
    #1 chk("clr_cnt", stall_cnt, 0);
    drain();

    // DEPTH=4, LOAD_READY=3: two stall cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    #1 chk("d4_lw_stall", stall4, 0);
    tick();
    dec(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    #1 chk("d4_stall_c1", stall4, 1);
    tick();
    #1 chk("d4_stall_c2", stall4, 1);
    tick();
    #1 chk("d4_stall_c3", stall4, 0);
    tick();
    idle();
    stage_wdata4[127:96] = 32'hCAFE_F00D;
    #1;
    chk("d4_fwd_a_en", fwd_a_en4, 1);
    chk("d4_fwd_a_data", fwd_a_data4, 32'hCAFE_F00D);
    chk("d4_fwd_b_data", fwd_b_data4, 32'hCAFE_F00D);
    chk("d4_cnt", stall_cnt4, 2);

    // chained lw x7,0(x7): 16 more stalls push the 4-bit counter past 15
    dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    repeat (25) tick();
    chk("d4_sat_cnt", stall_cnt4, 4'hF);
    for (int k = 0; k < 4 && stall4 !== 1'b1; k++) tick();
    chk("d4_stall_before_clr", stall4, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("d4_clr_cnt", stall_cnt4, 0);

    // reset in the middle of traffic drops all in-flight writers
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_stall", stall4, 0);
    chk("midrst_fwd_a_en", fwd_a_en4, 0);
    chk("midrst_cnt", stall_cnt4, 0);
    chk("midrst_dut_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
